// File: rtl/nes_dma_controller_pkg.sv
// Shared types and constants for the NES CPU-bus DMA controller.
// The DMC states exist only when DMA_DMC_EN is defined.
package nes_dma_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_OAM_RD = 3'd3,
    ST_OAM_WR = 3'd4
`ifdef DMA_DMC_EN
    ,
    ST_DMC_RD = 3'd5,
    ST_DUMMY  = 3'd6
`endif
  } dma_state_e;

  localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  function automatic logic [15:0] oam_src_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/nes_dma_controller_if.sv
// CPU-side and system-bus-side signals of the DMA controller.
// slave = controller view, master = CPU/bus/DMC-engine view.
interface nes_dma_controller_if;
  import nes_dma_controller_pkg::*;

  // cpu_* and din come from the CPU and bus; aout/dout/mr/mw drive the bus.
  // dmc_req is a level request held with a stable dmc_addr until dmc_ack,
  // a one-CPU-cycle pulse that qualifies dmc_data; req must not depend on ack.
  logic [15:0] cpu_aout;
  logic [7:0]  cpu_dout;
  logic        cpu_mr;
  logic        cpu_mw;
  logic [7:0]  din;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        cpu_ce;
  logic [15:0] aout;
  logic [7:0]  dout;
  logic        mr;
  logic        mw;
  logic        dmc_ack;
  logic [7:0]  dmc_data;
  logic        oam_busy;
  dma_state_e  dbg_state;

  modport slave (
    input  cpu_aout, cpu_dout, cpu_mr, cpu_mw, din, dmc_req, dmc_addr,
    output cpu_ce, aout, dout, mr, mw, dmc_ack, dmc_data, oam_busy, dbg_state
  );

  modport master (
    output cpu_aout, cpu_dout, cpu_mr, cpu_mw, din, dmc_req, dmc_addr,
    input  cpu_ce, aout, dout, mr, mw, dmc_ack, dmc_data, oam_busy, dbg_state
  );

endinterface

// File: rtl/nes_dma_controller_dma_bus_mux.sv
// Combinational bus source selection: CPU passthrough in IDLE, DMA cycles otherwise.
// The DMC address path exists only when DMA_DMC_EN is defined.
module dma_bus_mux
  import nes_dma_controller_pkg::*;
(
  input  dma_state_e  state_i,
  input  logic [15:0] cpu_aout_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_mr_i,
  input  logic        cpu_mw_i,
  input  logic [15:0] dmc_addr_i,
  input  logic [7:0]  page_i,
  input  logic [7:0]  idx_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] aout_o,
  output logic [7:0]  dout_o,
  output logic        mr_o,
  output logic        mw_o
);

`ifndef DMA_DMC_EN
  logic unused_dmc_addr;
  assign unused_dmc_addr = ^dmc_addr_i;
`endif

  // Halt, align and dummy cycles are reads of whatever the CPU is addressing.
  always_comb begin
    aout_o = cpu_aout_i;
    dout_o = cpu_dout_i;
    mr_o   = 1'b1;
    mw_o   = 1'b0;
    case (state_i)
      ST_IDLE: begin
        mr_o = cpu_mr_i;
        mw_o = cpu_mw_i;
      end
      ST_OAM_RD: aout_o = oam_src_addr(page_i, idx_i);
      ST_OAM_WR: begin
        aout_o = OAM_DATA_ADDR;
        dout_o = byte_i;
        mr_o   = 1'b0;
        mw_o   = 1'b1;
      end
`ifdef DMA_DMC_EN
      ST_DMC_RD: aout_o = dmc_addr_i;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/nes_dma_controller.sv
// NES OAM/DMC DMA sequencer: halts the CPU via cpu_ce and owns the bus while a DMA runs.
// Define DMA_DMC_EN to include the DMC sample-fetch path.
module nes_dma_controller
  import nes_dma_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  nes_dma_controller_if.slave  bus
);

  dma_state_e state_q, state_d, dispatch_s;
  logic       phase_q, phase_d;
  logic       oam_pend_q, oam_pend_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic       oam_start, oam_last;

  assign oam_start = bus.cpu_mw && (bus.cpu_aout == OAM_DMA_ADDR);
  assign oam_last  = (state_q == ST_OAM_WR) && (idx_q == 8'hFF);

`ifdef DMA_DMC_EN
  logic       dmc_ack_q, dmc_ack_d;
  logic [7:0] dmc_data_q, dmc_data_d;
  logic       dmc_want;

  // The request is still high during the ack cycle; masking it there stops a refetch.
  assign dmc_want   = bus.dmc_req && !dmc_ack_q;
  assign dispatch_s = dmc_want ? ST_DMC_RD :
                      (oam_pend_q && !oam_last) ? ST_OAM_RD : ST_IDLE;

  always_comb begin
    dmc_ack_d  = dmc_ack_q;
    dmc_data_d = dmc_data_q;
    if (ce) begin
      dmc_ack_d = (state_q == ST_DMC_RD);
      if (state_q == ST_DMC_RD) dmc_data_d = bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmc_ack_q  <= 1'b0;
      dmc_data_q <= 8'h00;
    end else begin
      dmc_ack_q  <= dmc_ack_d;
      dmc_data_q <= dmc_data_d;
    end
  end

  assign bus.dmc_ack  = dmc_ack_q;
  assign bus.dmc_data = dmc_data_q;
`else
  logic unused_dmc_req;
  assign unused_dmc_req = bus.dmc_req;
  assign dispatch_s     = (oam_pend_q && !oam_last) ? ST_OAM_RD : ST_IDLE;
  assign bus.dmc_ack    = 1'b0;
  assign bus.dmc_data   = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      oam_pend_q <= 1'b0;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      byte_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      oam_pend_q <= oam_pend_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
    end
  end

  // phase_q = 1 marks a put cycle, so the cycle after it is a get (dispatch point).
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    oam_pend_d = oam_pend_q;
    page_d     = page_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    if (ce) begin
      phase_d = ~phase_q;
      case (state_q)
        ST_IDLE: begin
          if (oam_start) begin
            page_d     = bus.cpu_dout;
            idx_d      = 8'h00;
            oam_pend_d = 1'b1;
            state_d    = ST_HALT;
          end
`ifdef DMA_DMC_EN
          if (dmc_want) state_d = ST_HALT;
`endif
        end
        ST_HALT:   state_d = phase_q ? dispatch_s : ST_ALIGN;
        ST_ALIGN:  state_d = dispatch_s;
        ST_OAM_RD: begin
          byte_d  = bus.din;
          state_d = ST_OAM_WR;
        end
        ST_OAM_WR: begin
          idx_d = idx_q + 8'd1;
          if (oam_last) oam_pend_d = 1'b0;
          state_d = dispatch_s;
        end
`ifdef DMA_DMC_EN
        ST_DMC_RD: state_d = oam_pend_q ? ST_DUMMY : ST_IDLE;
        ST_DUMMY:  state_d = dispatch_s;
`endif
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cpu_ce    = (state_q == ST_IDLE) ? ce : 1'b0;
    bus.oam_busy  = oam_pend_q;
    bus.dbg_state = state_q;
  end

  dma_bus_mux u_mux (
    .state_i    (state_q),
    .cpu_aout_i (bus.cpu_aout),
    .cpu_dout_i (bus.cpu_dout),
    .cpu_mr_i   (bus.cpu_mr),
    .cpu_mw_i   (bus.cpu_mw),
    .dmc_addr_i (bus.dmc_addr),
    .page_i     (page_q),
    .idx_i      (idx_q),
    .byte_i     (byte_q),
    .aout_o     (bus.aout),
    .dout_o     (bus.dout),
    .mr_o       (bus.mr),
    .mw_o       (bus.mw)
  );

endmodule

// File: doc/nes_dma_controller.md
# nes_dma_controller

Sequences CPU-bus sharing between the 6502 core and the two NES DMA engines: OAM DMA (write to $4014) and APU DMC sample fetch. Sits between the CPU core and the system bus. It gates the CPU clock enable while a DMA owns the bus and muxes address, data and strobes. All bus activity advances on the master CPU-cycle enable `ce`.

## Interface
Parameters: none (constants in shared include, see Structure).

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  CPU-cycle enable, one pulse per CPU cycle
- cpu_aout  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_mr  in  1  CPU read strobe
- cpu_mw  in  1  CPU write strobe
- din  in  8  bus read data
- dmc_req  in  1  DMC fetch request, level, held until ack
- dmc_addr  in  16  DMC sample address, stable while dmc_req
- cpu_ce  out  1  gated enable to CPU core
- aout  out  16  bus address
- dout  out  8  bus write data
- mr, mw  out  1  bus read/write strobes
- dmc_ack  out  1  one-cycle pulse, dmc_data valid
- dmc_data  out  8  fetched DMC byte, registered
- oam_busy  out  1  OAM DMA pending or running

## Operation
- `phase` register toggles on every ce; 0 = get, 1 = put. DMA reads occur only in get cycles.
- States: IDLE, HALT, ALIGN, OAM_RD, OAM_WR, DMC_RD, DUMMY. Each state lasts exactly one ce cycle.
- IDLE:
  - cpu_ce = ce; aout/dout/mr/mw pass through from the CPU.
  - On ce with cpu_mw && cpu_aout == $4014: latch page = cpu_dout, idx = 0, set oam_pend, go to HALT.
  - On ce with dmc_req: go to HALT.
- Every non-IDLE state: cpu_ce = 0.
- HALT: bus is a dummy read of cpu_aout (mr = 1, mw = 0). Next state is dispatch if the next cycle is get; otherwise ALIGN.
- ALIGN: same dummy read. Next state is dispatch.
- Dispatch, evaluated at entry to a get cycle, in priority order:
  - dmc_req → DMC_RD
  - oam_pend → OAM_RD
  - otherwise → IDLE
- DMC_RD: aout = dmc_addr, mr = 1. dmc_data <= din; dmc_ack pulses in the following cycle. Next state is DUMMY if oam_pend, else IDLE.
- DUMMY (put): dummy read of cpu_aout. Next state is dispatch.
- OAM_RD: aout = {page, idx}, mr = 1. Latch byte. Next state is OAM_WR.
- OAM_WR: aout = $2004, dout = byte, mw = 1. idx increments with 8-bit wrap; when idx == 255 before the increment, clear oam_pend. Next state is dispatch.
- A DMC fetch that steals a get slot delays the OAM sequence by 2 cycles. The OAM index is not advanced and no byte is lost.
- oam_busy = oam_pend.

## Timing
- Reset (async, any state): state IDLE, phase 0, oam_pend 0, idx 0, page 0, dmc_ack 0, dmc_data 0. Outputs are immediately CPU passthrough: cpu_ce = ce, aout = cpu_aout, mr = cpu_mr, mw = cpu_mw.
- Bus outputs are combinational from state. dmc_data and dmc_ack are registered.
- OAM stall from an IDLE start: 513 CPU cycles (HALT + 512) or 514 cycles (with ALIGN), plus 2 per interleaved DMC fetch.
- DMC stall from IDLE: 2 cycles (HALT, DMC_RD) or 3 cycles (with ALIGN).
- $4014 write and dmc_req in the same IDLE cycle: both are accepted, and DMC is served first.
- A dmc_req arriving mid-OAM is served at the next dispatch.
- A $4014 write is only recognised in IDLE.
- Between ce pulses all registers hold; only the combinational outputs follow their inputs.

## Configuration
- DMA_DMC_EN defined: DMC path, DMC_RD/DUMMY states and dispatch priority as specified.
- DMA_DMC_EN undefined: dmc_req ignored; dmc_ack and dmc_data tied to 0; DMC_RD/DUMMY states removed; OAM behaviour unchanged.

## Structure
- Shared include `dma_defs.vh` holds:
  - state encodings
  - OAM_DMA_ADDR = 16'h4014
  - OAM_DATA_ADDR = 16'h2004
- One natural sub-module: `dma_bus_mux`, a combinational selection of aout/dout/mr/mw from the state and the latched fields.

## Test plan
- OAM DMA, phase get at write: CPU writes $02 to $4014, RAM $0200–$02FF holds i^$5A.
  - 256 writes to $2004 with data 0^$5A … 255^$5A.
  - cpu_ce low for 513 cycles; oam_busy falls after the last write.
- Same as above, triggered in a put cycle: ALIGN inserted, stall is 514 cycles, data is identical.
- DMC from IDLE: dmc_req with dmc_addr = $C123, din = $A7.
  - One read of $C123.
  - dmc_ack pulses once and dmc_data = $A7.
  - Stall is 2 or 3 cycles, depending on phase.
- DMC during OAM: assert dmc_req at idx 100.
  - Exactly one $C123 read inserted.
  - OAM resumes at idx 100, no duplicate or skipped byte.
  - Total stall is 515 or 516 cycles.
- Reset mid-OAM: deassert reset_n at idx 37.
  - Outputs return to passthrough immediately, oam_busy = 0.
  - After release, a new $4014 write restarts at idx 0.
- Build without DMA_DMC_EN: dmc_req held high produces no bus reads and dmc_ack stays 0.
